lfsr_prbs_gen: RTL and testbench
================================

// Module: lfsr_prbs_gen
// PURPOSE
//   Parametrised PRBS generator: WIDTH-bit LFSR, Fibonacci or Galois form, tap mask set by parameter.
//   Emits a programmable-length burst of states over a valid/ready stream; seed reloadable at run time.
//   Feeds test-pattern, scrambler and BIST paths; sole next-generation free-running PRBS source.
// PARAMETERS
//   WIDTH  4      LFSR length in bits (2..64)
//   TAPS   4'h3   feedback mask, WIDTH bits; bit i set = state[i] participates in feedback
//   SEED   4'h9   reset/default state, WIDTH bits, must be non-zero
//   MODE   0      0 = Fibonacci, 1 = Galois
//   CNT_W  16     width of burst-length counter
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   seed_load  in   1      load seed_in into state; honoured in IDLE only
//   seed_in    in   WIDTH  seed value
//   start      in   1      begin burst of len beats; honoured in IDLE only
//   len        in   CNT_W  burst length, sampled on accepted start
//   stop       in   1      abort burst; honoured in RUN only
//   out_valid  out  1      beat available
//   out_ready  in   1      consumer accepts beat
//   out_data   out  WIDTH  current LFSR state
//   out_bit    out  1      out_data[0], the serial PRBS bit
//   busy       out  1      high in RUN
//   done       out  1      one-cycle pulse, burst complete
//   lockup     out  1      sticky zero-seed flag (see CONFIGURATION)
// BEHAVIOUR
//   Reset: state=SEED, FSM=IDLE, out_valid=0, busy=0, done=0, lockup=0, counter=0.
//   Step (one per accepted beat): Fibonacci: fb=^(state&TAPS); state<={fb,state[WIDTH-1:1]}.
//     Galois: state<=(state>>1) ^ (state[0] ? TAPS : 0).
//   FSM IDLE: out_valid=0; state holds. seed_load -> state<=seed_in next edge.
//     start & len!=0 -> counter<=len, RUN. start & len==0 -> stay IDLE, done pulse next cycle.
//     seed_load & start same cycle: seed loaded first; first beat of burst = seed_in.
//   FSM RUN: out_valid=1, busy=1, out_data=state (registered, 0 comb. latency from state).
//     out_valid & out_ready -> state steps, counter-=1; out_valid stays high while counter!=0.
//     Handshake with counter==1 -> IDLE, done=1 the following cycle. Holds data stable while !out_ready.
//     stop -> IDLE next edge, no done, state kept at current (un-accepted) value, counter cleared.
//     stop & final handshake same cycle: handshake completes, done pulses (completion wins).
//     seed_load/start in RUN ignored, no side effect.
//   Counter full-scale len=2^CNT_W-1 legal; no wrap. State sequence wraps naturally at LFSR period.
//   Async rst mid-burst: immediate return to reset values, no done.
// CONFIGURATION
//   LFSR_LOCKUP_RECOVER_EN defined: seed_load with seed_in==0 loads SEED instead, sets lockup=1;
//     lockup clears on next non-zero seed_load or rst.
//   Undefined: zero seed loaded verbatim (generator stuck at 0), lockup tied 0.
// STRUCTURE
//   lfsr_pkg: MODE_FIB/MODE_GAL localparams, FSM state enum {IDLE, RUN}.
//   Sub-module lfsr_step: combinational next-state function (WIDTH, TAPS, MODE); top holds FSM,
//     counter, state register, handshake.
// TESTING
//   Defaults, rst, start len=15, out_ready=1 -> out_data 9,C,6,B,5,A,D,E,F,7,3,1,8,4,2; done 1 cycle after beat 15.
//   Same burst with out_ready toggling 1/0 -> identical sequence, out_data stable while stalled, 15 handshakes.
//   MODE=1, WIDTH=4, TAPS=4'hC, seed 1 -> 15 distinct non-zero states, 16th beat returns to 1.
//   seed_load=1,seed_in=4'h5 with start len=2 same cycle -> beats 5,A; done pulse.
//   stop after 3 beats -> busy low next cycle, no done, next start resumes from 4th state.
//   seed_in=0 load: with LFSR_LOCKUP_RECOVER_EN -> state=9, lockup=1; without -> out_data=0 every beat.

Source files
------------

// File: rtl/lfsr_pkg.sv
// Shared constants and FSM encoding for the PRBS generator.
// LFSR form selectors and the two-state burst FSM.
package lfsr_pkg;

    localparam int MODE_FIB = 0;
    localparam int MODE_GAL = 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_e;

endpackage

// File: rtl/lfsr_prbs_gen_if.sv
// Beat stream carrying the LFSR state out of the generator.
// master = generator side, slave = consumer side.
interface lfsr_prbs_gen_if #(
    parameter int WIDTH = 4
);

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_bit;

    modport master (output out_valid, out_data, out_bit, input out_ready);
    modport slave  (input out_valid, out_data, out_bit, output out_ready);

endinterface

// File: rtl/lfsr_step.sv
// Combinational LFSR next-state function, Fibonacci or Galois form.
// A bit set in TAPS means that state bit takes part in the feedback.
module lfsr_step
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 'h3,
    parameter int               MODE  = MODE_FIB
) (
    input  logic [WIDTH-1:0] i_state,
    output logic [WIDTH-1:0] o_next
);

    generate
        if (MODE == MODE_GAL) begin : g_gal
            assign o_next = (i_state >> 1) ^ (i_state[0] ? TAPS : '0);
        end else begin : g_fib
            assign o_next = {^(i_state & TAPS), i_state[WIDTH-1:1]};
        end
    endgenerate

endmodule

// File: rtl/lfsr_prbs_gen.sv
// Burst PRBS generator: LFSR state streamed one beat per handshake for a programmed length.
// Optional LFSR_LOCKUP_RECOVER_EN replaces a zero seed load with SEED and raises a sticky lockup flag.
module lfsr_prbs_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 'h3,
    parameter logic [WIDTH-1:0] SEED  = 'h9,
    parameter int               MODE  = MODE_FIB,
    parameter int               CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_seed_load,
    input  logic [WIDTH-1:0]  i_seed_in,
    input  logic              i_start,
    input  logic [CNT_W-1:0]  i_len,
    input  logic              i_stop,
    lfsr_prbs_gen_if.master   o_stream,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_lockup
);

    fsm_e             r_fsm, w_fsm_nxt;
    logic [WIDTH-1:0] r_state, w_state_nxt, w_step, w_load_val;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_done, w_done_nxt;
    logic             w_hs;

    lfsr_step #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .MODE  (MODE)
    ) u_step (
        .i_state (r_state),
        .o_next  (w_step)
    );

`ifdef LFSR_LOCKUP_RECOVER_EN
    logic r_lockup, w_lockup_nxt;

    assign w_load_val = (i_seed_in == '0) ? SEED : i_seed_in;

    always_comb begin
        w_lockup_nxt = r_lockup;
        if (r_fsm == IDLE && i_seed_load) w_lockup_nxt = (i_seed_in == '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_lockup <= 1'b0;
        else     r_lockup <= w_lockup_nxt;
    end

    assign o_lockup = r_lockup;
`else
    assign w_load_val = i_seed_in;
    assign o_lockup   = 1'b0;
`endif

    assign w_hs = (r_fsm == RUN) && o_stream.out_ready;

    // A handshake on the last beat takes priority over a simultaneous stop.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_done_nxt  = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (i_seed_load) w_state_nxt = w_load_val;
                if (i_start) begin
                    if (i_len != '0) begin
                        w_cnt_nxt = i_len;
                        w_fsm_nxt = RUN;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            RUN: begin
                if (w_hs) begin
                    w_state_nxt = w_step;
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                    if (r_cnt == CNT_W'(1)) begin
                        w_fsm_nxt  = IDLE;
                        w_done_nxt = 1'b1;
                    end else if (i_stop) begin
                        w_fsm_nxt = IDLE;
                        w_cnt_nxt = '0;
                    end
                end else if (i_stop) begin
                    w_fsm_nxt = IDLE;
                    w_cnt_nxt = '0;
                end
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fsm   <= IDLE;
            r_state <= SEED;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign o_stream.out_valid = (r_fsm == RUN);
    assign o_stream.out_data  = r_state;
    assign o_stream.out_bit   = r_state[0];
    assign o_busy             = (r_fsm == RUN);
    assign o_done             = r_done;

endmodule

// File: tb/tb_lfsr_prbs_gen.sv
// Self-checking bench for lfsr_prbs_gen: per-cycle model compare plus literal sequence checks.
// Honours LFSR_LOCKUP_RECOVER_EN in its expectations.
module tb_lfsr_prbs_gen;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default-parameter Fibonacci instance
    logic        seed_load = 1'b0;
    logic [3:0]  seed_in   = 4'h0;
    logic        start     = 1'b0;
    logic [15:0] len       = 16'h0;
    logic        stop      = 1'b0;
    logic        busy, done, lockup;
    lfsr_prbs_gen_if #(.WIDTH(4)) s_if ();

    lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'h3), .SEED(4'h9), .MODE(0), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .i_seed_load(seed_load), .i_seed_in(seed_in),
        .i_start(start), .i_len(len), .i_stop(stop), .o_stream(s_if),
        .o_busy(busy), .o_done(done), .o_lockup(lockup)
    );

    // Galois instance with a 4-bit counter so full-scale length is 15
    logic        g_seed_load = 1'b0;
    logic [3:0]  g_seed_in   = 4'h0;
    logic        g_start     = 1'b0;
    logic [3:0]  g_len       = 4'h0;
    logic        g_stop      = 1'b0;
    logic        g_busy, g_done, g_lockup;
    lfsr_prbs_gen_if #(.WIDTH(4)) g_if ();

    lfsr_prbs_gen #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1), .MODE(1), .CNT_W(4)) gal (
        .clk(clk), .rst(rst), .i_seed_load(g_seed_load), .i_seed_in(g_seed_in),
        .i_start(g_start), .i_len(g_len), .i_stop(g_stop), .o_stream(g_if),
        .o_busy(g_busy), .o_done(g_done), .o_lockup(g_lockup)
    );

    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // Behavioural model of the default instance, stepped at each clock edge
    typedef struct packed {
        logic        busy;
        logic [3:0]  st;
        logic [16:0] rem;
        logic        done;
        logic        lock;
    } mdl_t;

    localparam logic [3:0] SEEDV = 4'h9;
    localparam logic [3:0] TAPSV = 4'h3;
`ifdef LFSR_LOCKUP_RECOVER_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    function automatic logic [3:0] fib_next(input logic [3:0] s);
        int ones;
        ones = $countones(s & TAPSV);
        return (s >> 1) | (4'(ones % 2) << 3);
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input logic sl, input logic [3:0] si,
                                      input logic st, input logic [15:0] ln, input logic sp,
                                      input logic rdy);
        mdl_t n;
        n = m;
        n.done = 1'b0;
        if (!m.busy) begin
            if (sl) begin
                if (LOCK_EN && si == 4'h0) begin
                    n.st = SEEDV; n.lock = 1'b1;
                end else begin
                    n.st = si; n.lock = 1'b0;
                end
            end
            if (st) begin
                if (ln == 16'h0) n.done = 1'b1;
                else begin n.busy = 1'b1; n.rem = {1'b0, ln}; end
            end
        end else if (rdy) begin
            n.st  = fib_next(m.st);
            n.rem = m.rem - 17'd1;
            if (n.rem == 17'd0) begin n.busy = 1'b0; n.done = 1'b1; end
            else if (sp) begin n.busy = 1'b0; n.rem = 17'd0; end
        end else if (sp) begin
            n.busy = 1'b0; n.rem = 17'd0;
        end
        return n;
    endfunction

    mdl_t m;
    always @(posedge clk or posedge rst) begin
        if (rst) m <= '{busy: 1'b0, st: SEEDV, rem: 17'd0, done: 1'b0, lock: 1'b0};
        else     m <= mdl_next(m, seed_load, seed_in, start, len, stop, s_if.out_ready);
    end

    always @(negedge clk) begin
        chk("valid",  64'(s_if.out_valid), 64'(m.busy));
        chk("busy",   64'(busy),           64'(m.busy));
        chk("data",   64'(s_if.out_data),  64'(m.st));
        chk("bit",    64'(s_if.out_bit),   64'(m.st[0]));
        chk("done",   64'(done),           64'(m.done));
        chk("lockup", 64'(lockup),         64'(m.lock));
    end

    // Beat/done logging: called right after inputs are set on a falling edge
    logic [3:0] beats[$];
    logic [3:0] gbeats[$];
    int ndone  = 0;
    int gndone = 0;

    task automatic cyc();
        if (s_if.out_valid && s_if.out_ready) beats.push_back(s_if.out_data);
        if (g_if.out_valid && g_if.out_ready) gbeats.push_back(g_if.out_data);
        @(negedge clk);
        if (done)   ndone++;
        if (g_done) gndone++;
    endtask

    task automatic clr();
        beats.delete();
        gbeats.delete();
        ndone  = 0;
        gndone = 0;
    endtask

    task automatic chk_beats(input string nm, input logic [3:0] exp[$]);
        chk({nm, "_count"}, 64'(beats.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < beats.size()) chk($sformatf("%s[%0d]", nm, i), 64'(beats[i]), 64'(exp[i]));
    endtask

    logic [3:0] exp_a[$] = '{4'h9, 4'hC, 4'h6, 4'hB, 4'h5, 4'hA, 4'hD, 4'hE,
                             4'hF, 4'h7, 4'h3, 4'h1, 4'h8, 4'h4, 4'h2};
    logic [3:0] exp_g[$] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                             4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

    initial begin
        logic [15:0] seen;
        s_if.out_ready = 1'b0;
        g_if.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_data",   64'(s_if.out_data),  64'(4'h9));
        chk("rst_valid",  64'(s_if.out_valid), 64'(0));
        chk("rst_busy",   64'(busy),           64'(0));
        chk("rst_lockup", 64'(lockup),         64'(0));
        chk("rst_gdata",  64'(g_if.out_data),  64'(4'h1));

        // Model sanity pinned by literals
        chk("model_fib9", 64'(fib_next(4'h9)), 64'(4'hC));
        chk("model_fib2", 64'(fib_next(4'h2)), 64'(4'h9));

        // Galois full period at full-scale length, then one more beat
        clr();
        g_if.out_ready = 1'b1; g_start = 1'b1; g_len = 4'hF; cyc();
        g_start = 1'b0; repeat (18) cyc();
        g_start = 1'b1; g_len = 4'h1; cyc();
        g_start = 1'b0; repeat (3) cyc();
        chk("gal_count", 64'(gbeats.size()), 64'(16));
        for (int i = 0; i < 16; i++)
            if (i < gbeats.size()) chk($sformatf("gal[%0d]", i), 64'(gbeats[i]), 64'(exp_g[i]));
        seen = '0;
        for (int i = 0; i < 15; i++) if (i < gbeats.size()) seen[gbeats[i]] = 1'b1;
        chk("gal_distinct", 64'(seen), 64'(16'hFFFE));
        chk("gal_done", 64'(gndone), 64'(2));

        // Fibonacci burst of 15, ready held high
        clr();
        s_if.out_ready = 1'b1; start = 1'b1; len = 16'd15; cyc();
        start = 1'b0; repeat (18) cyc();
        chk_beats("burstA", exp_a);
        chk("burstA_done", 64'(ndone), 64'(1));

        // Same burst with ready toggling
        clr();
        seed_load = 1'b1; seed_in = 4'h9; cyc();
        seed_load = 1'b0; start = 1'b1; len = 16'd15; s_if.out_ready = 1'b0; cyc();
        start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            s_if.out_ready = (k % 2 == 0);
            cyc();
        end
        chk_beats("burstB", exp_a);
        chk("burstB_done", 64'(ndone), 64'(1));

        // Seed load and start together
        clr();
        s_if.out_ready = 1'b1; seed_load = 1'b1; seed_in = 4'h5; start = 1'b1; len = 16'd2; cyc();
        seed_load = 1'b0; start = 1'b0; repeat (5) cyc();
        chk_beats("seedstart", '{4'h5, 4'hA});
        chk("seedstart_done", 64'(ndone), 64'(1));

        // Zero-length start: done pulse only
        clr();
        start = 1'b1; len = 16'd0; cyc();
        start = 1'b0; repeat (2) cyc();
        chk("len0_done", 64'(ndone), 64'(1));
        chk("len0_beats", 64'(beats.size()), 64'(0));

        // Stop after 3 beats, then resume
        clr();
        seed_load = 1'b1; seed_in = 4'h9; cyc();
        seed_load = 1'b0; start = 1'b1; len = 16'd15; cyc();
        start = 1'b0; repeat (3) cyc();
        s_if.out_ready = 1'b0; stop = 1'b1; cyc();
        stop = 1'b0;
        chk("stop_busy", 64'(busy), 64'(0));
        chk("stop_data", 64'(s_if.out_data), 64'(4'hB));
        repeat (2) cyc();
        chk("stop_nodone", 64'(ndone), 64'(0));
        s_if.out_ready = 1'b1; start = 1'b1; len = 16'd2; cyc();
        start = 1'b0; repeat (4) cyc();
        chk_beats("resume", '{4'h9, 4'hC, 4'h6, 4'hB, 4'h5});

        // Stop coinciding with the final handshake still completes
        clr();
        start = 1'b1; len = 16'd1; cyc();
        start = 1'b0; stop = 1'b1; cyc();
        stop = 1'b0; repeat (2) cyc();
        chk("stopfinal_done", 64'(ndone), 64'(1));

        // Zero seed load
        clr();
        seed_load = 1'b1; seed_in = 4'h0; cyc();
        seed_load = 1'b0;
        chk("zero_lockup", 64'(lockup), 64'(LOCK_EN));
        chk("zero_data", 64'(s_if.out_data), LOCK_EN ? 64'(4'h9) : 64'(4'h0));
        start = 1'b1; len = 16'd3; cyc();
        start = 1'b0; repeat (5) cyc();
        if (LOCK_EN) chk_beats("zero_burst", '{4'h9, 4'hC, 4'h6});
        else         chk_beats("zero_burst", '{4'h0, 4'h0, 4'h0});
        seed_load = 1'b1; seed_in = 4'h7; cyc();
        seed_load = 1'b0;
        chk("nz_lockup_clear", 64'(lockup), 64'(0));

        // Randomised traffic with one asynchronous reset in the middle
        for (int k = 0; k < 3000; k++) begin
            seed_load      = ($urandom_range(0, 15) == 0);
            seed_in        = 4'($urandom_range(0, 15));
            start          = ($urandom_range(0, 7) == 0);
            len            = 16'($urandom_range(0, 19));
            stop           = ($urandom_range(0, 31) == 0);
            s_if.out_ready = ($urandom_range(0, 9) < 7);
            if (k == 1500) begin
                #1 rst = 1'b1;
                #2 rst = 1'b0;
            end
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
